// File: rtl/buffer_narrow_to_wide.sv
// Narrow-to-wide packing FIFO: RATIO beats of IN_W bits become one word with a
// lane-valid mask, queued in a DEPTH-entry first-word-fall-through buffer.
module buffer_narrow_to_wide #(
  parameter int IN_W  = 128,
  parameter int RATIO = 4,
  parameter int DEPTH = 256,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [IN_W*RATIO-1:0] out_data,
  output logic [RATIO-1:0]      out_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LW-1:0]         level,
  output logic                  full,
  output logic                  empty
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int IW    = $clog2(RATIO);
  localparam int ENT_W = OUT_W + RATIO;
  localparam int AW    = LW - 1;

  logic [IW-1:0]    idx_q, idx_d;
  logic [OUT_W-1:0] lanes_q, lanes_d, placed_lanes;
  logic [RATIO-1:0] mask_q, mask_d, placed_mask;
  logic [LW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] head;
  logic             accept, beat, last, push, pop;

  // A flush with no lanes held is a pure strobe: its data is not a beat.
  assign accept = in_valid && in_ready;
  assign beat   = accept && !(flush && (mask_q == '0));
  assign last   = (idx_q == IW'(RATIO - 1));
  assign push   = beat && (last || flush);
  assign pop    = out_valid && out_ready;

  always_comb begin
    placed_lanes = lanes_q;
    placed_mask  = mask_q;
    idx_d        = idx_q;
    lanes_d      = lanes_q;
    mask_d       = mask_q;
    if (beat) begin
      placed_lanes[int'(idx_q)*IN_W +: IN_W] = in_data;
      placed_mask[idx_q]                     = 1'b1;
    end
    if (push) begin
      idx_d   = '0;
      lanes_d = '0;
      mask_d  = '0;
    end else if (beat) begin
      idx_d   = idx_q + 1'b1;
      lanes_d = placed_lanes;
      mask_d  = placed_mask;
    end
  end

  always_comb begin
    wptr_d  = push ? wptr_q + LW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + LW'(1) : rptr_q;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      lanes_q <= '0;
      mask_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (clr) begin
      idx_q   <= '0;
      lanes_q <= '0;
      mask_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
      mask_q  <= mask_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wptr_q[AW-1:0]] <= {placed_mask, placed_lanes};
  end

  assign head      = mem_q[rptr_q[AW-1:0]];
  assign level     = level_q;
  assign empty     = (level_q == '0);
  assign full      = (level_q == LW'(DEPTH));
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : head[OUT_W-1:0];
  assign out_mask  = empty ? '0 : head[ENT_W-1:OUT_W];

endmodule

// File: tb/tb_buffer_narrow_to_wide.sv
// Bench for buffer_narrow_to_wide: default 128x4/256 instance plus a small
// 16x2/4 instance for the full/back-pressure and pointer-wrap scenarios.
module tb_buffer_narrow_to_wide;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0;

  logic         clr0 = 1'b0, in_valid0 = 1'b0, flush0 = 1'b0, out_ready0 = 1'b0;
  logic [127:0] in_data0 = '0;
  logic         in_ready0, out_valid0, full0, empty0;
  logic [511:0] out_data0;
  logic [3:0]   out_mask0;
  logic [8:0]   level0;

  logic         clr1 = 1'b0, in_valid1 = 1'b0, flush1 = 1'b0, out_ready1 = 1'b0;
  logic [15:0]  in_data1 = '0;
  logic         in_ready1, out_valid1, full1, empty1;
  logic [31:0]  out_data1;
  logic [1:0]   out_mask1;
  logic [2:0]   level1;

  buffer_narrow_to_wide #(.IN_W(128), .RATIO(4), .DEPTH(256)) u0 (
    .clk(clk), .rst(rst), .clr(clr0), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .flush(flush0), .out_data(out_data0), .out_mask(out_mask0),
    .out_valid(out_valid0), .out_ready(out_ready0), .level(level0), .full(full0),
    .empty(empty0));

  buffer_narrow_to_wide #(.IN_W(16), .RATIO(2), .DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .clr(clr1), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .flush(flush1), .out_data(out_data1), .out_mask(out_mask1),
    .out_valid(out_valid1), .out_ready(out_ready1), .level(level1), .full(full1),
    .empty(empty1));

  typedef struct { logic [511:0] d; logic [3:0] m; } exp0_t;
  typedef struct { logic [31:0]  d; logic [1:0] m; } exp1_t;
  exp0_t q0[$];
  exp1_t q1[$];
  exp0_t e0;
  exp1_t e1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] w4(input logic [127:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic exp0(input logic [511:0] d, input logic [3:0] m);
    exp0_t e;
    e.d = d; e.m = m;
    q0.push_back(e);
  endtask

  task automatic exp1(input logic [31:0] d, input logic [1:0] m);
    exp1_t e;
    e.d = d; e.m = m;
    q1.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Holds the transfer until it is accepted, returning 1 time unit after that edge.
  task automatic send0(input logic [127:0] d, input logic fl);
    int  t = 0;
    logic acc;
    in_valid0 = 1'b1; in_data0 = d; flush0 = fl;
    forever begin
      @(negedge clk); acc = in_ready0;
      @(posedge clk); #1;
      if (acc) break;
      t++;
      if (t > 100) begin check("u0 accept timeout", 512'(in_ready0), 512'(1)); break; end
    end
    in_valid0 = 1'b0; flush0 = 1'b0;
  endtask

  task automatic send1(input logic [15:0] d, input logic fl);
    int  t = 0;
    logic acc;
    in_valid1 = 1'b1; in_data1 = d; flush1 = fl;
    forever begin
      @(negedge clk); acc = in_ready1;
      @(posedge clk); #1;
      if (acc) break;
      t++;
      if (t > 100) begin check("u1 accept timeout", 512'(in_ready1), 512'(1)); break; end
    end
    in_valid1 = 1'b0; flush1 = 1'b0;
  endtask

  task automatic check_reset0(input string tag);
    check({tag, " level"},     512'(level0),     512'(0));
    check({tag, " empty"},     512'(empty0),     512'(1));
    check({tag, " full"},      512'(full0),      512'(0));
    check({tag, " in_ready"},  512'(in_ready0),  512'(1));
    check({tag, " out_valid"}, 512'(out_valid0), 512'(0));
    check({tag, " out_data"},  out_data0,        512'(0));
    check({tag, " out_mask"},  512'(out_mask0),  512'(0));
  endtask

  always @(negedge clk) begin
    if (!rst && !clr0 && out_valid0 && out_ready0) begin
      if (q0.size() == 0) check("u0 spurious word", 512'(out_valid0), 512'(0));
      else begin
        e0 = q0.pop_front();
        check("u0 word data", out_data0, e0.d);
        check("u0 word mask", 512'(out_mask0), 512'(e0.m));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && !clr1 && out_valid1 && out_ready1) begin
      if (q1.size() == 0) check("u1 spurious word", 512'(out_valid1), 512'(0));
      else begin
        e1 = q1.pop_front();
        check("u1 word data", 512'(out_data1), 512'(e1.d));
        check("u1 word mask", 512'(out_mask1), 512'(e1.m));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, n_chk %0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] la, lb, lc, ld, le, lf, lg;
    la = {4{32'hA0A0_0001}}; lb = {4{32'hB0B0_0002}}; lc = {4{32'hC0C0_0003}};
    ld = {4{32'hD0D0_0004}}; le = {4{32'hE0E0_0005}}; lf = {4{32'hF0F0_0006}};
    lg = {4{32'h9090_0007}};

    #1 rst = 1'b1;
    idle(2);
    check_reset0("reset");
    check("u1 reset level", 512'(level1), 512'(0));
    check("u1 reset in_ready", 512'(in_ready1), 512'(1));
    rst = 1'b0;
    tick();

    // Two full words, latency of the first
    out_ready0 = 1'b1;
    exp0(w4(1, 2, 3, 4), 4'hF);
    exp0(w4(5, 6, 7, 8), 4'hF);
    for (int i = 1; i <= 3; i++) send0(128'(i), 1'b0);
    check("latency pre out_valid", 512'(out_valid0), 512'(0));
    send0(128'(4), 1'b0);
    check("latency out_valid", 512'(out_valid0), 512'(1));
    check("latency level", 512'(level0), 512'(1));
    for (int i = 5; i <= 8; i++) send0(128'(i), 1'b0);
    idle(4);
    check("basic drained level", 512'(level0), 512'(0));
    check("basic scoreboard", 512'(q0.size()), 512'(0));

    // Partial flush on third beat, then a normal word
    exp0(w4(la, lb, lc, 0), 4'b0111);
    exp0(w4(ld, le, lf, lg), 4'hF);
    send0(la, 1'b0); send0(lb, 1'b0); send0(lc, 1'b1);
    send0(ld, 1'b0); send0(le, 1'b0); send0(lf, 1'b0); send0(lg, 1'b0);
    idle(4);
    check("flush drained level", 512'(level0), 512'(0));
    check("flush scoreboard", 512'(q0.size()), 512'(0));

    // Empty flush is a no-op; flush on the 4th beat yields one word
    send0(128'hDEAD, 1'b1);
    check("empty flush level", 512'(level0), 512'(0));
    check("empty flush out_valid", 512'(out_valid0), 512'(0));
    exp0(w4(11, 12, 13, 14), 4'hF);
    send0(128'(11), 1'b0); send0(128'(12), 1'b0); send0(128'(13), 1'b0);
    send0(128'(14), 1'b1);
    idle(4);
    check("last flush level", 512'(level0), 512'(0));
    check("last flush scoreboard", 512'(q0.size()), 512'(0));

    // Simultaneous push and pop at level 2
    out_ready0 = 1'b0;
    exp0(w4(31, 32, 33, 34), 4'hF);
    exp0(w4(35, 36, 37, 38), 4'hF);
    exp0(w4(39, 40, 41, 42), 4'hF);
    for (int i = 31; i <= 41; i++) send0(128'(i), 1'b0);
    check("level before push+pop", 512'(level0), 512'(2));
    out_ready0 = 1'b1;
    send0(128'(42), 1'b0);
    out_ready0 = 1'b0;
    check("level after push+pop", 512'(level0), 512'(2));
    out_ready0 = 1'b1;
    idle(5);
    check("push+pop drained", 512'(level0), 512'(0));
    check("push+pop scoreboard", 512'(q0.size()), 512'(0));

    // Asynchronous reset with 3 words queued and 2 lanes held
    out_ready0 = 1'b0;
    for (int i = 0; i < 14; i++) send0(128'(100 + i), 1'b0);
    check("pre-rst level", 512'(level0), 512'(3));
    #2 rst = 1'b1;
    #1 check_reset0("async rst");
    tick();
    rst = 1'b0;
    out_ready0 = 1'b1;
    exp0(w4(21, 22, 23, 24), 4'hF);
    for (int i = 21; i <= 24; i++) send0(128'(i), 1'b0);
    idle(4);
    check("post-rst scoreboard", 512'(q0.size()), 512'(0));

    // Synchronous clear, same scenario
    out_ready0 = 1'b0;
    for (int i = 0; i < 14; i++) send0(128'(200 + i), 1'b0);
    check("pre-clr level", 512'(level0), 512'(3));
    clr0 = 1'b1;
    #1 check("clr waits for edge", 512'(level0), 512'(3));
    tick();
    check_reset0("clr");
    clr0 = 1'b0;
    out_ready0 = 1'b1;
    exp0(w4(51, 52, 53, 54), 4'hF);
    for (int i = 51; i <= 54; i++) send0(128'(i), 1'b0);
    idle(4);
    check("post-clr level", 512'(level0), 512'(0));
    check("post-clr scoreboard", 512'(q0.size()), 512'(0));

    // Small instance: fill, hold a beat, drain across 3 pointer wraps
    out_ready1 = 1'b0;
    for (int j = 0; j < 12; j++) exp1({16'(2*j + 2), 16'(2*j + 1)}, 2'b11);
    for (int b = 1; b <= 8; b++) send1(16'(b), 1'b0);
    check("u1 full level", 512'(level1), 512'(4));
    check("u1 full flag", 512'(full1), 512'(1));
    check("u1 in_ready low", 512'(in_ready1), 512'(0));
    in_valid1 = 1'b1; in_data1 = 16'(9); flush1 = 1'b0;
    idle(3);
    check("u1 held level", 512'(level1), 512'(4));
    out_ready1 = 1'b1;
    send1(16'(9), 1'b0);
    for (int b = 10; b <= 24; b++) send1(16'(b), 1'b0);
    idle(8);
    check("u1 drained level", 512'(level1), 512'(0));
    check("u1 drained empty", 512'(empty1), 512'(1));
    check("u1 scoreboard", 512'(q1.size()), 512'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
